// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the execute stage: the ARM data-processing opcodes, the
// condition codes, the NZCV flag record and a few opcode classification
// helpers.
// ---------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
      OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
      OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
      OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
   } opcode_e;

   typedef enum logic [3:0] {
      CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3,
      CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7,
      CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11,
      CC_GT = 4'd12, CC_LE = 4'd13, CC_AL = 4'd14, CC_NV = 4'd15
   } cond_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   localparam cond_e COND_AL = CC_AL;

   // Compare-only ops: flags always update, no register write.
   function automatic logic is_compare(input opcode_e op);
      return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
   endfunction

   // Ops whose carry comes from the shifter rather than the adder.
   function automatic logic is_logical(input opcode_e op);
      return (op == OP_AND) || (op == OP_EOR) || (op == OP_TST) || (op == OP_TEQ) ||
             (op == OP_ORR) || (op == OP_MOV) || (op == OP_BIC) || (op == OP_MVN);
   endfunction

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Combinational ARM condition-code check.
//   cond  in  4  condition field
//   nzcv  in  4  current flags (N in bit 3)
//   pass  out 1  instruction should execute
// Code 1111 is treated as always.
// ---------------------------------------------------------------------------
module cond_eval
   import alu_pkg::*;
(
   input  logic [3:0] cond,
   input  nzcv_t      nzcv,
   output logic       pass
);

   always_comb begin
      pass = 1'b1;
      case (cond_e'(cond))
         CC_EQ: pass = nzcv.z;
         CC_NE: pass = !nzcv.z;
         CC_CS: pass = nzcv.c;
         CC_CC: pass = !nzcv.c;
         CC_MI: pass = nzcv.n;
         CC_PL: pass = !nzcv.n;
         CC_VS: pass = nzcv.v;
         CC_VC: pass = !nzcv.v;
         CC_HI: pass = nzcv.c && !nzcv.z;
         CC_LS: pass = !nzcv.c || nzcv.z;
         CC_GE: pass = (nzcv.n == nzcv.v);
         CC_LT: pass = (nzcv.n != nzcv.v);
         CC_GT: pass = !nzcv.z && (nzcv.n == nzcv.v);
         CC_LE: pass = nzcv.z || (nzcv.n != nzcv.v);
         default: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/exec_alu_stage.sv
// ---------------------------------------------------------------------------
// exec_alu_stage
// Registered execute stage: ARM data-processing ALU, condition check, NZCV
// flag register and a one-entry valid/ready output register.
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   upstream handshake (in_ready = !out_valid || out_ready)
//   in_cond, in_opcode    condition field and data-processing opcode
//   in_s, in_rd           set-flags bit, destination index
//   in_rn, in_src2        first operand, shifted second operand
//   in_sh_c, in_sh_c_vld  shifter carry-out and its qualifier
//   out_valid / out_ready downstream handshake
//   out_result, out_rd    ALU result and destination index
//   out_wr_en, out_exec   register-write required, condition passed
//   flags                 current NZCV (N in bit 3)
// Build option: COND_EXEC_EN enables condition evaluation; when undefined
// every instruction executes and cond_eval is not instantiated.
// ---------------------------------------------------------------------------
module exec_alu_stage
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_cond,
   input  logic [3:0]  in_opcode,
   input  logic        in_s,
   input  logic [3:0]  in_rd,
   input  logic [31:0] in_rn,
   input  logic [31:0] in_src2,
   input  logic        in_sh_c,
   input  logic        in_sh_c_vld,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [3:0]  out_rd,
   output logic        out_wr_en,
   output logic        out_exec,
   output logic [3:0]  flags
);

   nzcv_t       flags_q;
   nzcv_t       flags_d;
   opcode_e     op;
   logic        accept;
   logic        cond_pass;
   logic        cmp_op;
   logic        upd_flags;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        cin;
   logic [32:0] sum;
   logic [31:0] res;

   assign op       = opcode_e'(in_opcode);
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign cmp_op   = is_compare(op);
   assign flags    = flags_q;

`ifdef COND_EXEC_EN
   cond_eval u_cond_eval (
      .cond (in_cond),
      .nzcv (flags_q),
      .pass (cond_pass)
   );
`else
   logic unused_cond;
   assign unused_cond = ^in_cond;
   assign cond_pass   = 1'b1;
`endif

   // Adder operands: b is pre-inverted for subtractions, RSB/RSC swap a/b.
   always_comb begin
      opa = in_rn;
      opb = in_src2;
      cin = 1'b0;
      case (op)
         OP_ADC:         cin = flags_q.c;
         OP_SUB, OP_CMP: begin opb = ~in_src2; cin = 1'b1; end
         OP_SBC:         begin opb = ~in_src2; cin = flags_q.c; end
         OP_RSB:         begin opa = in_src2; opb = ~in_rn; cin = 1'b1; end
         OP_RSC:         begin opa = in_src2; opb = ~in_rn; cin = flags_q.c; end
         default:        ;
      endcase
   end

   assign sum = {1'b0, opa} + {1'b0, opb} + {32'd0, cin};

   always_comb begin
      res = sum[31:0];
      case (op)
         OP_AND, OP_TST: res = in_rn & in_src2;
         OP_EOR, OP_TEQ: res = in_rn ^ in_src2;
         OP_ORR:         res = in_rn | in_src2;
         OP_MOV:         res = in_src2;
         OP_BIC:         res = in_rn & ~in_src2;
         OP_MVN:         res = ~in_src2;
         default:        ;
      endcase
   end

   assign upd_flags = accept && cond_pass && (in_s || cmp_op);

   always_comb begin
      flags_d   = flags_q;
      flags_d.n = res[31];
      flags_d.z = (res == 32'd0);
      if (is_logical(op)) begin
         if (in_sh_c_vld) flags_d.c = in_sh_c;
      end else begin
         flags_d.c = sum[32];
         flags_d.v = (opa[31] == opb[31]) && (res[31] != opa[31]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else if (upd_flags) begin
         flags_q <= flags_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_rd     <= '0;
         out_wr_en  <= 1'b0;
         out_exec   <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_result <= cond_pass ? res : 32'd0;
         out_rd     <= in_rd;
         out_wr_en  <= cond_pass && !cmp_op;
         out_exec   <= cond_pass;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_exec_alu_stage.sv
// ---------------------------------------------------------------------------
// tb_exec_alu_stage
// Directed vectors with hand-computed expectations for exec_alu_stage.
// Condition-dependent expectations follow the COND_EXEC_EN build option.
// ---------------------------------------------------------------------------
module tb_exec_alu_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_cond;
   logic [3:0]  in_opcode;
   logic        in_s;
   logic [3:0]  in_rd;
   logic [31:0] in_rn;
   logic [31:0] in_src2;
   logic        in_sh_c;
   logic        in_sh_c_vld;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_rd;
   logic        out_wr_en;
   logic        out_exec;
   logic [3:0]  flags;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   exec_alu_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_cond     (in_cond),
      .in_opcode   (in_opcode),
      .in_s        (in_s),
      .in_rd       (in_rd),
      .in_rn       (in_rn),
      .in_src2     (in_src2),
      .in_sh_c     (in_sh_c),
      .in_sh_c_vld (in_sh_c_vld),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_rd      (out_rd),
      .out_wr_en   (out_wr_en),
      .out_exec    (out_exec),
      .flags       (flags)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present an instruction at the falling edge, then sample #1 after the
   // following rising edge.
   task automatic issue(input logic [3:0] cond, input logic [3:0] op, input logic s,
                        input logic [3:0] rd, input logic [31:0] rn, input logic [31:0] src2,
                        input logic shc, input logic shcv);
      @(negedge clk);
      in_valid    = 1'b1;
      in_cond     = cond;
      in_opcode   = op;
      in_s        = s;
      in_rd       = rd;
      in_rn       = rn;
      in_src2     = src2;
      in_sh_c     = shc;
      in_sh_c_vld = shcv;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_cond = 4'd14; in_opcode = 4'd0; in_s = 1'b0; in_rd = 4'd0;
      in_rn = '0; in_src2 = '0; in_sh_c = 1'b0; in_sh_c_vld = 1'b0;
      #12;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_flags",     {28'd0, flags},     32'd0);
      check("rst_result",    out_result,         32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADDS overflow: 0x7FFFFFFF + 1
      issue(4'd14, 4'd4, 1'b1, 4'd1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      check("adds_result", out_result, 32'h8000_0000);
      check("adds_flags",  {28'd0, flags}, 32'b1001);
      check("adds_wr_en",  {31'd0, out_wr_en}, 32'd1);
      check("adds_valid",  {31'd0, out_valid}, 32'd1);
      check("adds_rd",     {28'd0, out_rd}, 32'd1);

      // SUBS equal operands, then back-to-back MOVEQ sees Z=1
      issue(4'd14, 4'd2, 1'b1, 4'd2, 32'd5, 32'd5, 1'b0, 1'b0);
      check("subs_result", out_result, 32'd0);
      check("subs_flags",  {28'd0, flags}, 32'b0110);
      issue(4'd0, 4'd13, 1'b0, 4'd4, 32'd0, 32'hAB, 1'b0, 1'b0);
      check("moveq_exec",   {31'd0, out_exec}, 32'd1);
      check("moveq_result", out_result, 32'hAB);
      check("moveq_flags",  {28'd0, flags}, 32'b0110);

      // ADDS 1+1 clears all flags
      issue(4'd14, 4'd4, 1'b1, 4'd5, 32'd1, 32'd1, 1'b0, 1'b0);
      check("adds2_result", out_result, 32'd2);
      check("adds2_flags",  {28'd0, flags}, 32'b0000);

      // MOVEQ with Z=0
      issue(4'd0, 4'd13, 1'b0, 4'd3, 32'd0, 32'h1, 1'b0, 1'b0);
      check("movne_rd", {28'd0, out_rd}, 32'd3);
`ifdef COND_EXEC_EN
      check("movfail_exec",   {31'd0, out_exec},  32'd0);
      check("movfail_wr_en",  {31'd0, out_wr_en}, 32'd0);
      check("movfail_result", out_result, 32'd0);
`else
      check("movfail_exec",   {31'd0, out_exec},  32'd1);
      check("movfail_wr_en",  {31'd0, out_wr_en}, 32'd1);
      check("movfail_result", out_result, 32'd1);
`endif
      check("movfail_flags", {28'd0, flags}, 32'b0000);

      // Set V, then ANDS keeps V and takes shifter carry
      issue(4'd14, 4'd4, 1'b1, 4'd1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      check("adds3_flags", {28'd0, flags}, 32'b1001);
      issue(4'd14, 4'd0, 1'b1, 4'd6, 32'hF0, 32'h0F, 1'b1, 1'b1);
      check("ands_result", out_result, 32'd0);
      check("ands_flags",  {28'd0, flags}, 32'b0111);
      issue(4'd14, 4'd0, 1'b1, 4'd6, 32'hF0, 32'h0F, 1'b0, 1'b0);
      check("ands_keepc_flags", {28'd0, flags}, 32'b0111);

      // CMP 3,5 with S=0: flags still update, no write
      issue(4'd14, 4'd10, 1'b0, 4'd7, 32'd3, 32'd5, 1'b0, 1'b0);
      check("cmp_flags", {28'd0, flags}, 32'b1000);
      check("cmp_wr_en", {31'd0, out_wr_en}, 32'd0);

      // RSBS: 10 - 3
      issue(4'd14, 4'd3, 1'b1, 4'd8, 32'd3, 32'd10, 1'b0, 1'b0);
      check("rsbs_result", out_result, 32'd7);
      check("rsbs_flags",  {28'd0, flags}, 32'b0010);

      // ADD with S=0 leaves flags
      issue(4'd14, 4'd4, 1'b0, 4'd9, 32'd0, 32'd0, 1'b0, 1'b0);
      check("add_nos_flags", {28'd0, flags}, 32'b0010);

      // SBCS with C=1: 10 - 3
      issue(4'd14, 4'd6, 1'b1, 4'd9, 32'd10, 32'd3, 1'b0, 1'b0);
      check("sbcs_result", out_result, 32'd7);
      check("sbcs_flags",  {28'd0, flags}, 32'b0010);

      // ADC with C=1: 1 + 1 + 1
      issue(4'd14, 4'd5, 1'b0, 4'd10, 32'd1, 32'd1, 1'b0, 1'b0);
      check("adc_result", out_result, 32'd3);

      // Drain without accept
      idle_cycle();
      check("drain_valid", {31'd0, out_valid}, 32'd0);

      // Stall: load an entry with out_ready low, then hold for 3 cycles
      @(negedge clk);
      out_ready = 1'b0;
      issue(4'd14, 4'd13, 1'b0, 4'd11, 32'd0, 32'h55, 1'b0, 1'b0);
      check("stall_load_valid", {31'd0, out_valid}, 32'd1);
      in_opcode = 4'd15; in_src2 = 32'd0; in_rd = 4'd12;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         check("stall_result",   out_result, 32'h55);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("replace_valid",  {31'd0, out_valid}, 32'd1);
      check("replace_result", out_result, 32'hFFFF_FFFF);
      check("replace_rd",     {28'd0, out_rd}, 32'd12);

      // Hold an entry, then reset mid-stall
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_valid",    {31'd0, out_valid}, 32'd0);
      check("midrst_flags",    {28'd0, flags},     32'd0);
      check("midrst_in_ready", {31'd0, in_ready},  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("postrst_in_ready", {31'd0, in_ready},  32'd1);
      check("postrst_valid",    {31'd0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exec_alu_stage.md
# exec_alu_stage

Registered execute stage that consumes the second operand and shifter carry produced by the operand-shift stage, together with Rn and the decoded data-processing fields. It performs the 16 ARM data-processing operations and evaluates the condition code. It maintains the architectural NZCV flag register and delivers a one-entry registered result to writeback over a valid/ready handshake.

## Interface

- No parameters; datapath is fixed at 32 bits.
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_cond  in  4  ARM condition field
- in_opcode  in  4  data-processing opcode, AND=0 … MVN=15
- in_s  in  1  set-flags bit
- in_rd  in  4  destination register index
- in_rn  in  32  first operand value
- in_src2  in  32  shifted second operand from the shift stage
- in_sh_c  in  1  shifter carry-out
- in_sh_c_vld  in  1  in_sh_c is meaningful; 0 means the shifter left carry unchanged
- out_valid  out  1  result register holds a valid entry
- out_ready  in  1  writeback accepts this cycle
- out_result  out  32  ALU result
- out_rd  out  4  destination index
- out_wr_en  out  1  register write required
- out_exec  out  1  condition passed
- flags  out  4  current NZCV, N in bit 3

## Operation

- Accept when in_valid && in_ready, where in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
- Condition evaluation uses the flags register value at the accept edge. Codes 0000–1110 follow the ARM definitions. 1111 is treated as AL.
- Operations:
  - AND, EOR, ORR, BIC, MOV and MVN are logical.
  - ADD, ADC and CMN are additions.
  - SUB, SBC, CMP, RSB and RSC are subtractions; RSB and RSC swap operands.
  - TST, TEQ, CMP and CMN are compare-only: out_wr_en=0, and flags update regardless of in_s.
- Arithmetic is computed in 33 bits as a + b' + cin:
  - ADD/CMN: b'=b, cin=0.
  - ADC: b'=b, cin=C.
  - SUB/CMP: b'=~b, cin=1.
  - SBC: b'=~b, cin=C.
  - C = bit 32.
  - V = (a[31]==b'[31]) && (res[31]!=a[31]).
- Flag update occurs only when the condition passes and (in_s or compare-only). For every such update, N=res[31] and Z=(res==0).
  - Arithmetic ops: C and V from the adder.
  - Logical ops: C=in_sh_c if in_sh_c_vld, otherwise unchanged; V is unchanged.
- Condition failed: the entry is still accepted and emitted with out_exec=0, out_wr_en=0, out_result=0 and out_rd=in_rd. Flags are unchanged.
- The flags register is written at the accept edge, so the next accepted instruction, including a back-to-back one, sees the updated flags.

## Timing

- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle while out_ready=1.
- Output fields are stable while out_valid && !out_ready.
- Accept and drain in the same cycle: the new entry replaces the old one and out_valid stays 1.
- Drain with no accept: out_valid goes to 0 on the next edge.
- Reset (asynchronous, any cycle, including mid-stall):
  - out_valid=0, out_result=0, out_rd=0, out_wr_en=0, out_exec=0, flags=0000.
  - in_ready=1 while in reset.
  - A held entry is discarded.

## Configuration

- COND_EXEC_EN defined: condition evaluation as described above.
- COND_EXEC_EN undefined: in_cond is ignored, every instruction executes (out_exec is always 1 on valid entries), and the condition sub-module is not instantiated.

## Structure

- Package alu_pkg:
  - opcode_e enum (16 values)
  - cond_e enum (16 values)
  - nzcv_t packed struct {n,z,c,v}
  - constant COND_AL
- Sub-module cond_eval: combinational (cond, nzcv) -> pass. It is the only sub-module. The ALU and flag logic stay in exec_alu_stage.

## Test plan

- Reset is released. Accept ADD with S=1, rn=0x7FFFFFFF, src2=1 -> next cycle out_result=0x80000000, flags=1001 (N,V), out_wr_en=1.
- SUB with S=1, rn=5, src2=5 -> result 0, flags=0110 (Z,C). Then a back-to-back BEQ-conditioned (cond=0000) MOV with src2=0xAB -> out_exec=1, result 0xAB.
- Flags are Z=0. MOV with cond=0000 and src2=0x1 -> out_exec=0, out_wr_en=0, flags unchanged. With COND_EXEC_EN undefined, the same stimulus gives out_exec=1, result 0x1.
- ANDS with rn=0xF0, src2=0x0F, in_sh_c=1, in_sh_c_vld=1 -> result 0, flags Z=1, C=1, V unchanged. Repeat with in_sh_c_vld=0 -> C is kept.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_result held. Raise out_ready -> drain and accept in the same cycle, out_valid stays 1.
- Assert rst_n=0 mid-stall with out_valid=1 -> out_valid=0 and flags=0000 immediately. After release, in_ready=1.
